lfsr_chk: RTL and testbench



---
 rtl/lfsr_chk.sv | 198 +++++++++++++++++++
 tb/tb_lfsr_chk.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_chk.sv
// lfsr_chk -- receive-side checker for an 8-bit Fibonacci PRBS stream.
//
// The generator emits its whole shift register each cycle:
//   next = {cur[6:0], cur[7]^cur[5]^cur[4]^cur[3]}
// The checker predicts each sample from the previous accepted one. It
// self-synchronises, declares lock after LOCK_CNT consecutive matches and
// counts mismatches while locked. LOSS_CNT consecutive mismatches drop it
// back to hunting.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous, active-high reset
//   in_valid   in   in_data carries a sample this cycle
//   in_data    in   [7:0] received LFSR sample
//   clr_cnt    in   synchronous clear of err_cnt, word_cnt, lost_lock, zero_seen
//   locked     out  checker is in LOCKED
//   err_pulse  out  previous accepted sample mismatched while LOCKED
//   err_cnt    out  [CNT_W-1:0] saturating mismatch count (LOCKED only)
//   word_cnt   out  [CNT_W-1:0] saturating count of checks made in LOCKED
//   lost_lock  out  sticky, set on each LOCKED->HUNT transition
//   zero_seen  out  sticky, an accepted sample was 0x00
//
// Build option: define LFSR_CHK_BITCNT_EN to make err_cnt accumulate the
// number of differing bits per mismatching check instead of one per check.

module lfsr_chk #(
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] word_cnt,
    output logic             lost_lock,
    output logic             zero_seen
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(LOSS_CNT + 1);

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e             state_q,     state_d;
    logic               have_prev_q, have_prev_d;
    logic [7:0]         prev_q,      prev_d;
    logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
    logic [MISS_W-1:0]  miss_cnt_q,  miss_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q,   err_cnt_d;
    logic [CNT_W-1:0]   word_cnt_q,  word_cnt_d;
    logic               err_pulse_q, err_pulse_d;
    logic               lost_lock_q, lost_lock_d;
    logic               zero_seen_q, zero_seen_d;

    logic [7:0]         pred;
    logic               mismatch;
    logic [3:0]         err_inc;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
    endfunction

    // Saturating add of a small increment (0..8) to a CNT_W counter.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [3:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W - 3){1'b0}}, inc};
        if (sum[CNT_W]) begin
            return {CNT_W{1'b1}};
        end
        return sum[CNT_W-1:0];
    endfunction

`ifdef LFSR_CHK_BITCNT_EN
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, v[i]};
        end
        return cnt;
    endfunction
`endif

    always_comb begin
        pred     = lfsr_next(prev_q);
        // 0x00 is the LFSR lock-up state; it can never be a legal sample
        // even when the prediction itself collapsed to zero.
        mismatch = (in_data != pred) || (in_data == 8'h00);
`ifdef LFSR_CHK_BITCNT_EN
        err_inc  = popcount8(in_data ^ pred);
`else
        err_inc  = 4'd1;
`endif
    end

    always_comb begin
        state_d     = state_q;
        have_prev_d = have_prev_q;
        prev_d      = prev_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_cnt_d   = err_cnt_q;
        word_cnt_d  = word_cnt_q;
        err_pulse_d = 1'b0;
        lost_lock_d = lost_lock_q;
        zero_seen_d = zero_seen_q;

        if (in_valid) begin
            // prev follows the stream even on mismatches so a single bad
            // sample costs exactly two mismatching checks.
            prev_d      = in_data;
            have_prev_d = 1'b1;
            if (in_data == 8'h00) begin
                zero_seen_d = 1'b1;
            end

            if (have_prev_q) begin
                if (state_q == ST_HUNT) begin
                    if (mismatch) begin
                        match_cnt_d = '0;
                    end else begin
                        match_cnt_d = match_cnt_q + MATCH_W'(1);
                        if (match_cnt_q == MATCH_W'(LOCK_CNT - 1)) begin
                            state_d    = ST_LOCKED;
                            miss_cnt_d = '0;
                        end
                    end
                end else begin
                    word_cnt_d = sat_add(word_cnt_q, 4'd1);
                    if (mismatch) begin
                        err_cnt_d   = sat_add(err_cnt_q, err_inc);
                        err_pulse_d = 1'b1;
                        miss_cnt_d  = miss_cnt_q + MISS_W'(1);
                        if (miss_cnt_q == MISS_W'(LOSS_CNT - 1)) begin
                            state_d     = ST_HUNT;
                            match_cnt_d = '0;
                            lost_lock_d = 1'b1;
                        end
                    end else begin
                        miss_cnt_d = '0;
                    end
                end
            end
        end

        // Clear wins over any same-cycle increment or flag set.
        if (clr_cnt) begin
            err_cnt_d   = '0;
            word_cnt_d  = '0;
            err_pulse_d = 1'b0;
            lost_lock_d = 1'b0;
            zero_seen_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_HUNT;
            have_prev_q <= 1'b0;
            prev_q      <= 8'h00;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            err_cnt_q   <= '0;
            word_cnt_q  <= '0;
            err_pulse_q <= 1'b0;
            lost_lock_q <= 1'b0;
            zero_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            have_prev_q <= have_prev_d;
            prev_q      <= prev_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            err_cnt_q   <= err_cnt_d;
            word_cnt_q  <= word_cnt_d;
            err_pulse_q <= err_pulse_d;
            lost_lock_q <= lost_lock_d;
            zero_seen_q <= zero_seen_d;
        end
    end

    assign locked    = (state_q == ST_LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
    assign word_cnt  = word_cnt_q;
    assign lost_lock = lost_lock_q;
    assign zero_seen = zero_seen_q;

endmodule

// File: tb/tb_lfsr_chk.sv
// Testbench for lfsr_chk: directed scenarios followed by a randomized run,
// every cycle compared against a sequence-table reference model.
module tb_lfsr_chk;

    localparam int LOCK = 8;
    localparam int LOSS = 4;
    localparam int CW   = 6;
    localparam int MAXC = (1 << CW) - 1;
`ifdef LFSR_CHK_BITCNT_EN
    localparam int ERR38 = 3;
`else
    localparam int ERR38 = 1;
`endif

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          clr_cnt;
    logic          locked;
    logic          err_pulse;
    logic [CW-1:0] err_cnt;
    logic [CW-1:0] word_cnt;
    logic          lost_lock;
    logic          zero_seen;

    lfsr_chk #(.LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .word_cnt  (word_cnt),
        .lost_lock (lost_lock),
        .zero_seen (zero_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // The full 255-long PRBS period and the position of each value in it.
    logic [7:0] seq [255];
    int         pos [256];
    int         gidx;

    // Reference model state.
    bit         m_locked, m_have, m_pulse, m_lost, m_zero;
    logic [7:0] m_prev;
    int         m_match, m_miss, m_err, m_word;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pred_of(input logic [7:0] p);
        if (pos[p] < 0) return 8'h00;
        return seq[(pos[p] + 1) % 255];
    endfunction

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    task automatic model_edge(input bit r, input bit v, input logic [7:0] d, input bit c);
        logic [7:0] p;
        bit mm;
        bit pulse_ev = 0, lost_ev = 0, zero_ev = 0;
        int err_add = 0, word_add = 0;
        if (r) begin
            m_locked = 0; m_have = 0; m_pulse = 0; m_lost = 0; m_zero = 0;
            m_prev = 8'h00; m_match = 0; m_miss = 0; m_err = 0; m_word = 0;
            return;
        end
        if (v) begin
            if (d == 8'h00) zero_ev = 1;
            if (m_have) begin
                p  = pred_of(m_prev);
                mm = (d != p) || (d == 8'h00);
                if (m_locked) begin
                    word_add = 1;
                    if (mm) begin
`ifdef LFSR_CHK_BITCNT_EN
                        err_add = $countones(d ^ p);
`else
                        err_add = 1;
`endif
                        pulse_ev = 1;
                        m_miss++;
                        if (m_miss == LOSS) begin
                            m_locked = 0; m_match = 0; m_miss = 0; lost_ev = 1;
                        end
                    end else begin
                        m_miss = 0;
                    end
                end else if (mm) begin
                    m_match = 0;
                end else begin
                    m_match++;
                    if (m_match == LOCK) begin
                        m_locked = 1; m_miss = 0;
                    end
                end
            end
            m_prev = d;
            m_have = 1;
        end
        if (c) begin
            m_err = 0; m_word = 0; m_pulse = 0; m_lost = 0; m_zero = 0;
        end else begin
            m_err   = sat(m_err + err_add);
            m_word  = sat(m_word + word_add);
            m_pulse = pulse_ev;
            if (lost_ev) m_lost = 1;
            if (zero_ev) m_zero = 1;
        end
    endtask

    task automatic check_model();
        chk("m_locked",    32'(locked),    32'(m_locked));
        chk("m_err_pulse", 32'(err_pulse), 32'(m_pulse));
        chk("m_err_cnt",   32'(err_cnt),   32'(m_err));
        chk("m_word_cnt",  32'(word_cnt),  32'(m_word));
        chk("m_lost_lock", 32'(lost_lock), 32'(m_lost));
        chk("m_zero_seen", 32'(zero_seen), 32'(m_zero));
    endtask

    task automatic cyc(input bit r, input bit v, input logic [7:0] d, input bit c);
        @(negedge clk);
        rst = r; in_valid = v; in_data = d; clr_cnt = c;
        @(posedge clk);
        model_edge(r, v, d, c);
        #1;
        check_model();
    endtask

    task automatic send_true(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(0, 1, seq[gidx], 0);
            gidx = (gidx + 1) % 255;
        end
    endtask

    task automatic send_bad(input logic [7:0] x, input bit c);
        cyc(0, 1, seq[gidx] ^ x, c);
        gidx = (gidx + 1) % 255;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_locked"},    32'(locked),    0);
        chk({tag, "_err_pulse"}, 32'(err_pulse), 0);
        chk({tag, "_err_cnt"},   32'(err_cnt),   0);
        chk({tag, "_word_cnt"},  32'(word_cnt),  0);
        chk({tag, "_lost_lock"}, 32'(lost_lock), 0);
        chk({tag, "_zero_seen"}, 32'(zero_seen), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        int w;
        bit r, vv, c;
        int sel;
        logic [7:0] d;

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; clr_cnt = 1'b0;
        for (int i = 0; i < 256; i++) pos[i] = -1;
        v = 8'hFF;
        for (int i = 0; i < 255; i++) begin
            seq[i] = v;
            pos[v] = i;
            v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        end
        gidx = 0;

        // Reset state.
        cyc(1, 0, 8'h00, 0);
        cyc(1, 0, 8'h00, 0);
        check_all_zero("reset");

        // Acquire lock from FF,FE,FC,...
        chk("seq_start", 32'(seq[5]), 32'h00E1);
        send_true(8);
        chk("lock_8th_sample", 32'(locked), 0);
        send_true(1);
        chk("lock_9th_sample", 32'(locked), 1);
        chk("lock_err_cnt", 32'(err_cnt), 0);
        send_true(20);
        chk("lock_word_cnt_20", 32'(word_cnt), 20);
        chk("lock_err_cnt_20", 32'(err_cnt), 0);

        // Single corrupted sample: two mismatching checks.
        cyc(0, 0, 8'h00, 1);
        send_bad(8'h01, 0);
        chk("corrupt_pulse1", 32'(err_pulse), 1);
        send_true(1);
        chk("corrupt_pulse2", 32'(err_pulse), 1);
        chk("corrupt_err_cnt", 32'(err_cnt), 2);
        send_true(1);
        chk("corrupt_pulse_off", 32'(err_pulse), 0);
        chk("corrupt_err_cnt_hold", 32'(err_cnt), 2);
        chk("corrupt_locked", 32'(locked), 1);
        chk("corrupt_lost_lock", 32'(lost_lock), 0);

        // Four zero samples force loss of lock.
        cyc(0, 0, 8'h00, 1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 8'h00, 0);
        chk("zero3_locked", 32'(locked), 1);
        cyc(0, 1, 8'h00, 0);
        chk("zero4_locked", 32'(locked), 0);
        chk("zero4_lost_lock", 32'(lost_lock), 1);
        chk("zero4_zero_seen", 32'(zero_seen), 1);
`ifndef LFSR_CHK_BITCNT_EN
        chk("zero4_err_cnt", 32'(err_cnt), 4);
`endif
        send_true(8);
        chk("relock_not_yet", 32'(locked), 0);
        send_true(1);
        chk("relock", 32'(locked), 1);
        chk("relock_lost_sticky", 32'(lost_lock), 1);

        // Valid gap.
        cyc(0, 0, 8'h00, 1);
        send_true(3);
        w = int'(word_cnt);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 8'h5A, 0);
            chk("gap_word_hold", 32'(word_cnt), 32'(w));
        end
        send_true(2);
        chk("gap_word_cnt", 32'(word_cnt), 5);
        chk("gap_err_cnt", 32'(err_cnt), 0);

        // Clear colliding with a mismatch, then reset while locked.
        send_bad(8'h10, 1);
        chk("clr_err_cnt", 32'(err_cnt), 0);
        chk("clr_err_pulse", 32'(err_pulse), 0);
        chk("clr_locked", 32'(locked), 1);
        chk("clr_word_cnt", 32'(word_cnt), 0);
        cyc(1, 1, seq[gidx], 1);
        check_all_zero("rst_locked");

        // Three-bit error on one check.
        gidx = 0;
        send_true(9);
        chk("b38_locked", 32'(locked), 1);
        cyc(0, 0, 8'h00, 1);
        cyc(0, 1, pred_of(seq[(gidx + 254) % 255]) ^ 8'h38, 0);
        gidx = (gidx + 1) % 255;
        chk("b38_err_cnt", 32'(err_cnt), 32'(ERR38));
        send_true(3);

        // Counter saturation.
        cyc(0, 0, 8'h00, 1);
        for (int i = 0; i < 40; i++) begin
            send_bad(8'h01, 0);
            send_true(2);
        end
        chk("sat_locked", 32'(locked), 1);
        chk("sat_err_cnt", 32'(err_cnt), 32'(MAXC));
        chk("sat_word_cnt", 32'(word_cnt), 32'(MAXC));

        // Randomized traffic.
        for (int k = 0; k < 800; k++) begin
            r   = ($urandom_range(0, 199) == 0);
            c   = ($urandom_range(0, 29) == 0);
            vv  = ($urandom_range(0, 3) != 0);
            sel = int'($urandom_range(0, 99));
            if (sel < 85)      d = seq[gidx];
            else if (sel < 95) d = seq[gidx] ^ 8'($urandom_range(1, 255));
            else               d = 8'h00;
            if (vv) gidx = (gidx + 1) % 255;
            cyc(r, vv, d, c);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
